bus_arbiter_rr: RTL and testbench
=================================

# bus_arbiter_rr

Round-robin arbiter and sequencer for a shared 4-source, w-bit data bus. Four requesters raise `req` bits. The block grants exactly one of them at a time and drives the 2-bit select of a 4:1 bus multiplexer so that the granted source's data appears on `o`. A programmable hold limit prevents any one requester from monopolising the bus.

## Interface
- `w`, 4: data width of each source and of `o`.
- `MAX_HOLD`, 4: maximum consecutive cycles one grant may last (≥1).
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in 4: request per source; bit i belongs to `d<i>`.
- `d0`, `d1`, `d2`, `d3` in w each: source data.
- `gnt` out 4: one-hot grant, registered; all zero when the bus is idle.
- `s` out 2: registered mux select, equal to the index of the granted source.
- `valid` out 1: registered; high while any grant is active.
- `o` out w: equals `d[s]` when `valid`=1, otherwise all zeros. It is combinational from `s`, `valid` and `d*`.

## Operation
- **Reset** (`rst_n`=0, asynchronous): `gnt`=0, `s`=0, `valid`=0, `o`=0, state=IDLE, `hold_cnt`=0, `ptr`=0.
- **Priority.** `ptr` is the highest-priority index. The search order is `ptr`, `ptr`+1, … modulo 4. The first index with its `req` bit high wins.
- **IDLE:**
  - If `req`≠0, grant the winner: `gnt`=onehot(i), `s`=i, `valid`=1, `hold_cnt`=1, go to GRANT.
  - Otherwise stay in IDLE with outputs zero.
- **GRANT** (owner i). The grant ends at a clock edge when `req[i]`=0 or `hold_cnt`=`MAX_HOLD`. On that edge:
  - `ptr` becomes (i+1) mod 4.
  - Arbitration runs immediately with the new `ptr` over the current `req`.
  - If the search finds a winner j, grant it on the same edge with `hold_cnt`=1. There is no idle gap. j may equal i only if i is the sole requester and was cut off by the hold limit; in that case i is re-granted.
  - If there is no winner, go to IDLE with `gnt`=0, `valid`=0, `s` holding its last value.
- **Otherwise in GRANT**, `hold_cnt` increments and the grant is held.
- Requests from other sources never pre-empt the owner before the end condition.
- `hold_cnt` width is clog2(`MAX_HOLD`+1). It saturates and never wraps.
- When `MAX_HOLD`=1, every grant lasts exactly one cycle. This gives strict round-robin rotation per cycle.
- **Reset mid-grant** immediately clears all outputs. After release of `rst_n`, arbitration restarts from `ptr`=0.
- **Invariant:** `gnt` is always zero or one-hot, and `gnt`≠0 exactly when `valid`=1.

## Timing
- **Request to grant:** 1 cycle. `req` is sampled at edge k; `gnt`, `s` and `valid` change after edge k.
- **Data path:** `o` follows `d[s]` combinationally in the same cycle, with no pipeline stage.
- **Release:** `req[i]` low at edge k ends the grant after edge k. The next grant, or idle, is visible after that same edge.
- **Maximum ownership:** `MAX_HOLD` cycles. Worst-case wait for a continuously requesting source is 3·`MAX_HOLD` cycles plus 1.

## Structure
- **Shared package `bus_arb_pkg`** holds:
  - `NUM_SRC`=4 and `SEL_W`=2.
  - The state enum {IDLE, GRANT}.
  - The default `MAX_HOLD`.
  - A function `rr_pick(req, ptr)` returning a found flag and an index.
- **Sub-module `bus_mux4`** (parameter `w`): a 4:1 select of `d0`..`d3` by `s`, gated to zero by `valid`. Only a driven mux is used, with no tri-state assigns, so `o` never floats.
- **Top** holds the FSM, `ptr`, `hold_cnt` and the grant registers.

## Test plan
- **Reset:** `rst_n`=0 while `req`=4'b1111 → `gnt`=0, `valid`=0, `o`=0. After release, the first grant is `gnt`=4'b0001, `s`=0.
- **Single requester, release:** `req`=4'b0100 for 2 cycles with `d2`=7 → `gnt`=4'b0100, `s`=2, `o`=7 for 2 cycles. Then `valid`=0, `o`=0.
- **Hold limit rotation:** `MAX_HOLD`=4, `req`=4'b1111 held high → grants in order 0,1,2,3,0. Each lasts 4 cycles with no idle cycle between grants.
- **Sole requester at limit:** `req`=4'b0010 held → `gnt` stays 4'b0010 continuously. `hold_cnt` cycles 1..4, and the grant is re-issued at each limit.
- **No pre-emption:** source 3 owns the bus and `req[0]` rises mid-grant → `gnt` stays 4'b1000 until `req[3]` drops. Next cycle `gnt`=4'b0001, `o`=`d0`.
- **Reset mid-grant:** `rst_n` pulses low during a source-2 grant → outputs clear asynchronously. After release with `req`=4'b0110, the grant goes to source 1 (`ptr`=0).

Source files
------------

// File: rtl/bus_arb_pkg.sv
// Shared types, constants and round-robin search helper for the 4-source bus arbiter.
package bus_arb_pkg;

    localparam int NUM_SRC      = 4;
    localparam int SEL_W        = 2;
    localparam int MAX_HOLD_DEF = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } pick_t;

    // Descending walk so the index closest to ptr is the last one written and wins.
    function automatic pick_t rr_pick(input logic [NUM_SRC-1:0] req, input logic [SEL_W-1:0] ptr);
        pick_t            p;
        logic [SEL_W-1:0] j;
        p = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            j = ptr + SEL_W'(k);
            if (req[j]) begin
                p.found = 1'b1;
                p.idx   = j;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_if.sv
// Request/data/grant bundle between four bus sources and the round-robin arbiter.
interface bus_arbiter_rr_if #(parameter int w = 4);
    import bus_arb_pkg::*;

    logic [NUM_SRC-1:0] req;
    logic [w-1:0]       d0;
    logic [w-1:0]       d1;
    logic [w-1:0]       d2;
    logic [w-1:0]       d3;
    logic [NUM_SRC-1:0] gnt;
    logic [SEL_W-1:0]   s;
    logic               valid;
    logic [w-1:0]       o;

    modport slave  (input  req, d0, d1, d2, d3, output gnt, s, valid, o);
    modport master (output req, d0, d1, d2, d3, input  gnt, s, valid, o);

endinterface

// File: rtl/bus_mux4.sv
// Driven 4:1 data select, forced to zero whenever no grant is active.
module bus_mux4 #(
    parameter int w = 4
) (
    input  logic [w-1:0] i_d0,
    input  logic [w-1:0] i_d1,
    input  logic [w-1:0] i_d2,
    input  logic [w-1:0] i_d3,
    input  logic [1:0]   i_s,
    input  logic         i_valid,
    output logic [w-1:0] o_data
);

    always_comb begin
        o_data = '0;
        if (i_valid) begin
            case (i_s)
                2'd0:    o_data = i_d0;
                2'd1:    o_data = i_d1;
                2'd2:    o_data = i_d2;
                default: o_data = i_d3;
            endcase
        end
    end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter with per-grant hold limit driving the select of a shared 4-source bus.
//   state | meaning
//   IDLE  | no grant; arbitrate from r_ptr each cycle
//   GRANT | source r_s owns the bus; r_hold counts cycles owned
module bus_arbiter_rr
    import bus_arb_pkg::*;
#(
    parameter int w        = 4,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    bus_arbiter_rr_if.slave bus
);

    localparam int HW = $clog2(MAX_HOLD + 1);

    state_t             r_state;
    logic [HW-1:0]      r_hold;
    logic [SEL_W-1:0]   r_ptr;
    logic [SEL_W-1:0]   r_s;
    logic [NUM_SRC-1:0] r_gnt;
    logic               r_valid;

    logic               w_end;
    logic [SEL_W-1:0]   w_arb_ptr;
    pick_t              w_pick;
    logic [w-1:0]       w_o;

    assign w_end     = (r_state == GRANT) && (!bus.req[r_s] || (r_hold == HW'(MAX_HOLD)));
    // At the end of a grant the search starts just past the owner, so handover needs no idle cycle.
    assign w_arb_ptr = (r_state == GRANT) ? r_s + SEL_W'(1) : r_ptr;
    assign w_pick    = rr_pick(bus.req, w_arb_ptr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_hold  <= '0;
            r_ptr   <= '0;
            r_s     <= '0;
            r_gnt   <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick.found) begin
                        r_gnt   <= NUM_SRC'(1) << w_pick.idx;
                        r_s     <= w_pick.idx;
                        r_valid <= 1'b1;
                        r_hold  <= HW'(1);
                        r_state <= GRANT;
                    end
                end
                GRANT: begin
                    if (w_end) begin
                        r_ptr <= w_arb_ptr;
                        if (w_pick.found) begin
                            r_gnt   <= NUM_SRC'(1) << w_pick.idx;
                            r_s     <= w_pick.idx;
                            r_valid <= 1'b1;
                            r_hold  <= HW'(1);
                        end else begin
                            r_gnt   <= '0;
                            r_valid <= 1'b0;
                            r_hold  <= '0;
                            r_state <= IDLE;
                        end
                    end else if (r_hold != HW'(MAX_HOLD)) begin
                        r_hold <= r_hold + HW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    bus_mux4 #(.w(w)) u_mux (
        .i_d0   (bus.d0),
        .i_d1   (bus.d1),
        .i_d2   (bus.d2),
        .i_d3   (bus.d3),
        .i_s    (r_s),
        .i_valid(r_valid),
        .o_data (w_o)
    );

    assign bus.gnt   = r_gnt;
    assign bus.s     = r_s;
    assign bus.valid = r_valid;
    assign bus.o     = w_o;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench for bus_arbiter_rr: vector table plus hand-written multi-cycle sequences.
module tb_bus_arbiter_rr;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    bus_arbiter_rr_if #(.w(4)) bif ();

    bus_arbiter_rr #(.w(4), .MAX_HOLD(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] s;
        logic       v;
        logic [3:0] o;
    } vec_t;

    vec_t       tv [14];
    logic [3:0] dv [4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
    endtask

    task automatic chk_bus(input string nm, input logic [3:0] g, input logic [1:0] s,
                           input logic v, input logic [3:0] o);
        chk({nm, ".gnt"},   32'(bif.gnt),   32'(g));
        chk({nm, ".s"},     32'(bif.s),     32'(s));
        chk({nm, ".valid"}, 32'(bif.valid), 32'(v));
        chk({nm, ".o"},     32'(bif.o),     32'(o));
    endtask

    initial begin
        int owner;
        checks   = 0;
        failures = 0;
        dv[0] = 4'hA; dv[1] = 4'h5; dv[2] = 4'h7; dv[3] = 4'hC;
        bif.d0 = dv[0]; bif.d1 = dv[1]; bif.d2 = dv[2]; bif.d3 = dv[3];

        tv[0]  = '{4'b0000, 4'b0000, 2'd0, 1'b0, 4'h0};
        tv[1]  = '{4'b0100, 4'b0100, 2'd2, 1'b1, 4'h7};
        tv[2]  = '{4'b0100, 4'b0100, 2'd2, 1'b1, 4'h7};
        tv[3]  = '{4'b0000, 4'b0000, 2'd2, 1'b0, 4'h0};
        tv[4]  = '{4'b0001, 4'b0001, 2'd0, 1'b1, 4'hA};
        tv[5]  = '{4'b0011, 4'b0001, 2'd0, 1'b1, 4'hA};
        tv[6]  = '{4'b0010, 4'b0010, 2'd1, 1'b1, 4'h5};
        tv[7]  = '{4'b1010, 4'b0010, 2'd1, 1'b1, 4'h5};
        tv[8]  = '{4'b1000, 4'b1000, 2'd3, 1'b1, 4'hC};
        tv[9]  = '{4'b1000, 4'b1000, 2'd3, 1'b1, 4'hC};
        tv[10] = '{4'b1000, 4'b1000, 2'd3, 1'b1, 4'hC};
        tv[11] = '{4'b1000, 4'b1000, 2'd3, 1'b1, 4'hC};
        tv[12] = '{4'b1000, 4'b1000, 2'd3, 1'b1, 4'hC};
        tv[13] = '{4'b0000, 4'b0000, 2'd3, 1'b0, 4'h0};

        // Reset held with all sources requesting
        rst_n   = 1'b0;
        bif.req = 4'b1111;
        #12;
        chk_bus("rst_hold", 4'b0000, 2'd0, 1'b0, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk_bus("rst_first", 4'b0001, 2'd0, 1'b1, 4'hA);

        // Full contention: four-cycle grants rotating 0,1,2,3,0 back to back
        for (int c = 2; c <= 17; c++) begin
            step();
            owner = ((c - 1) / 4) % 4;
            chk_bus($sformatf("rot%0d", c), 4'(1 << owner), 2'(owner), 1'b1, dv[owner]);
        end

        bif.req = 4'b0000;
        do_reset();
        for (int i = 0; i < 14; i++) begin
            bif.req = tv[i].req;
            step();
            chk_bus($sformatf("vec%0d", i), tv[i].gnt, tv[i].s, tv[i].v, tv[i].o);
        end

        // Sole requester re-granted at every hold limit
        bif.req = 4'b0010;
        for (int c = 0; c < 12; c++) begin
            step();
            chk($sformatf("sole%0d.gnt", c), 32'(bif.gnt), 32'h2);
            chk($sformatf("sole%0d.hold", c), 32'(dut.r_hold), 32'((c % 4) + 1));
        end

        // No pre-emption of source 3 by a later request from source 0
        bif.req = 4'b0000;
        do_reset();
        bif.req = 4'b1000;
        step();
        chk_bus("np_own", 4'b1000, 2'd3, 1'b1, 4'hC);
        bif.req = 4'b1001;
        step();
        chk_bus("np_hold1", 4'b1000, 2'd3, 1'b1, 4'hC);
        step();
        chk_bus("np_hold2", 4'b1000, 2'd3, 1'b1, 4'hC);
        bif.req = 4'b0001;
        step();
        chk_bus("np_next", 4'b0001, 2'd0, 1'b1, 4'hA);

        // Reset pulse in the middle of a source-2 grant
        bif.req = 4'b0000;
        do_reset();
        bif.req = 4'b0100;
        step();
        step();
        chk_bus("mr_pre", 4'b0100, 2'd2, 1'b1, 4'h7);
        #2;
        rst_n = 1'b0;
        #1;
        chk_bus("mr_async", 4'b0000, 2'd0, 1'b0, 4'h0);
        bif.req = 4'b0110;
        #2;
        rst_n = 1'b1;
        step();
        chk_bus("mr_after", 4'b0010, 2'd1, 1'b1, 4'h5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Grant must be zero or one-hot and agree with valid at every sample point
    always @(negedge clk) begin
        if (rst_n) begin
            chk("inv.onehot0", 32'($onehot0(bif.gnt)), 32'h1);
            chk("inv.valid", 32'(bif.valid), 32'(bif.gnt != 4'b0000));
        end
    end

endmodule
